// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the rst_seq reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        MEM  = 2'd1,
        IO   = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam int CAUSE_W    = 5;
    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_BTN  = 1;
    localparam int CAUSE_WDOG = 2;
    localparam int CAUSE_SW   = 3;
    localparam int CAUSE_TMO  = 4;

    localparam logic [CAUSE_W-1:0] CAUSE_POR_VAL = CAUSE_W'(1) << CAUSE_POR;
    localparam logic [CAUSE_W-1:0] CAUSE_TMO_VAL = CAUSE_W'(1) << CAUSE_TMO;

endpackage

// File: rtl/rst_seq_sync.sv
// Two-flop synchroniser with a configurable value loaded while in reset.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RST_VAL;
            q_reg    <= RST_VAL;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: merges reset requests, stretches them, releases mem/io/cpu in order.
// Define RST_SEQ_TIMEOUT_EN to retry the sequence when mem_ready never arrives.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int MEM_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_in_n,
    input  logic               btn_rst_n,
    input  logic               wdog_rst_req,
    input  logic               sw_rst_req,
    input  logic               mem_ready,
    output logic               rst_mem,
    output logic               rst_io,
    output logic               rst_cpu,
    output logic               done,
    output logic [CAUSE_W-1:0] cause
);

    localparam int CNT_MAX = (HOLD_CYCLES > MEM_TIMEOUT) ? HOLD_CYCLES : MEM_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(MEM_TIMEOUT - 1);
`endif

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               rst_mem_reg;
    logic               rst_io_reg;
    logic               rst_cpu_reg;
    logic               done_reg;
    logic [CAUSE_W-1:0] cause_reg;

    logic               btn_sync;
    logic [CAUSE_W-1:0] req_bits;
    logic               req;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_btn_sync (
        .clk   (clk),
        .rst_n (rst_in_n),
        .d     (btn_rst_n),
        .q     (btn_sync)
    );

    always_comb begin
        req_bits             = '0;
        req_bits[CAUSE_BTN]  = ~btn_sync;
        req_bits[CAUSE_WDOG] = wdog_rst_req;
        req_bits[CAUSE_SW]   = sw_rst_req;
    end

    assign req = |req_bits;

    // Outputs are loaded on the edge that enters each state, so they stay glitch-free.
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_reg   <= HOLD;
            cnt_reg     <= '0;
            rst_mem_reg <= 1'b1;
            rst_io_reg  <= 1'b1;
            rst_cpu_reg <= 1'b1;
            done_reg    <= 1'b0;
            cause_reg   <= CAUSE_POR_VAL;
        end else if (req) begin
            state_reg   <= HOLD;
            cnt_reg     <= '0;
            rst_mem_reg <= 1'b1;
            rst_io_reg  <= 1'b1;
            rst_cpu_reg <= 1'b1;
            done_reg    <= 1'b0;
            cause_reg   <= req_bits;
        end else begin
            unique case (state_reg)
                HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_reg   <= MEM;
                        cnt_reg     <= '0;
                        rst_mem_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        state_reg  <= IO;
                        cnt_reg    <= '0;
                        rst_io_reg <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
                    end else if (cnt_reg == TMO_LAST) begin
                        state_reg   <= HOLD;
                        cnt_reg     <= '0;
                        rst_mem_reg <= 1'b1;
                        cause_reg   <= CAUSE_TMO_VAL;
`endif
                    end else if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                IO: begin
                    state_reg   <= RUN;
                    rst_cpu_reg <= 1'b0;
                    done_reg    <= 1'b1;
                end
                RUN: begin
                end
                default: begin
                    state_reg <= HOLD;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign rst_mem = rst_mem_reg;
    assign rst_io  = rst_io_reg;
    assign rst_cpu = rst_cpu_reg;
    assign done    = done_reg;
    assign cause   = cause_reg;

endmodule

// File: tb/tb_rst_seq.sv
// Directed, table-driven bench for rst_seq; covers power-on, request merging,
// stretching, mem_ready wait (or timeout retry when RST_SEQ_TIMEOUT_EN) and async reset.
module tb_rst_seq;
    import rst_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_in_n;
    logic       btn_rst_n;
    logic       wdog_rst_req;
    logic       sw_rst_req;
    logic       mem_ready;
    logic       rst_mem;
    logic       rst_io;
    logic       rst_cpu;
    logic       done;
    logic [4:0] cause;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       btn_n;
        logic       wdog;
        logic       sw;
        logic       mrdy;
        state_t     st;
        logic [4:0] cause;
    } vec_t;

    vec_t tbl[$];

    rst_seq #(
        .HOLD_CYCLES (16),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst_in_n     (rst_in_n),
        .btn_rst_n    (btn_rst_n),
        .wdog_rst_req (wdog_rst_req),
        .sw_rst_req   (sw_rst_req),
        .mem_ready    (mem_ready),
        .rst_mem      (rst_mem),
        .rst_io       (rst_io),
        .rst_cpu      (rst_cpu),
        .done         (done),
        .cause        (cause)
    );

    always #5 clk = ~clk;

    // Expected {rst_mem, rst_io, rst_cpu, done, cause} for a given phase.
    function automatic logic [8:0] outs(input state_t st, input logic [4:0] c);
        case (st)
            HOLD:    return {4'b1110, c};
            MEM:     return {4'b0110, c};
            IO:      return {4'b0010, c};
            default: return {4'b0001, c};
        endcase
    endfunction

    task automatic chk(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {rst_mem, rst_io, rst_cpu, done, cause};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got mem/io/cpu/done/cause=%b required %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic b, input logic w, input logic s, input logic m,
                       input state_t st, input logic [4:0] c);
        vec_t v;
        v.btn_n = b; v.wdog = w; v.sw = s; v.mrdy = m; v.st = st; v.cause = c;
        tbl.push_back(v);
    endtask

    initial begin
        // sw pulse from RUN, then watchdog held 5 cycles, then stretch and release
        add(1, 0, 1, 1, HOLD, 5'b01000);
        for (int i = 0; i < 5; i++)  add(1, 1, 0, 1, HOLD, 5'b00100);
        for (int i = 0; i < 15; i++) add(1, 0, 0, 1, HOLD, 5'b00100);
        add(1, 0, 0, 1, MEM, 5'b00100);
        add(1, 0, 0, 1, IO,  5'b00100);
        add(1, 0, 0, 1, RUN, 5'b00100);

        rst_in_n = 1'b0; btn_rst_n = 1'b1; wdog_rst_req = 1'b0;
        sw_rst_req = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("por_reset_values", outs(HOLD, 5'b00001));

        // Power-on release: edges 16/17/18
        rst_in_n = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            step();
            chk($sformatf("por_edge%0d", e),
                outs(e < 16 ? HOLD : e == 16 ? MEM : e == 17 ? IO : RUN, 5'b00001));
        end

        // mem_ready dropping in RUN changes nothing
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("run_mrdy_low%0d", i), outs(RUN, 5'b00001));
        end
        mem_ready = 1'b1;

        foreach (tbl[i]) begin
            btn_rst_n = tbl[i].btn_n; wdog_rst_req = tbl[i].wdog;
            sw_rst_req = tbl[i].sw;   mem_ready = tbl[i].mrdy;
            step();
            chk($sformatf("vec%0d", i), outs(tbl[i].st, tbl[i].cause));
        end
        wdog_rst_req = 1'b0; sw_rst_req = 1'b0;

        // Button and software together: software first, button 2 edges later
        btn_rst_n = 1'b0; sw_rst_req = 1'b1;
        step(); chk("btnsw_e1", outs(HOLD, 5'b01000));
        btn_rst_n = 1'b1; sw_rst_req = 1'b0;
        step(); chk("btnsw_e2", outs(HOLD, 5'b01000));
        step(); chk("btnsw_e3", outs(HOLD, 5'b00010));
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("btnsw_hold%0d", i), outs(HOLD, 5'b00010));
        end
        step(); chk("btnsw_mem", outs(MEM, 5'b00010));
        step(); chk("btnsw_io",  outs(IO,  5'b00010));
        step(); chk("btnsw_run", outs(RUN, 5'b00010));

        // Power-on with mem_ready low
        rst_in_n = 1'b0; mem_ready = 1'b0;
        #1;
        chk("por2_reset_values", outs(HOLD, 5'b00001));
        step();
        rst_in_n = 1'b1;
        repeat (15) step();
        chk("por2_still_hold", outs(HOLD, 5'b00001));
        step(); chk("por2_mem", outs(MEM, 5'b00001));
`ifdef RST_SEQ_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("tmo_mem%0d", i), outs(MEM, 5'b00001));
        end
        step(); chk("tmo_hold", outs(HOLD, 5'b10000));
        repeat (15) step();
        chk("tmo_still_hold", outs(HOLD, 5'b10000));
        step(); chk("tmo_retry_mem", outs(MEM, 5'b10000));
        mem_ready = 1'b1;
        step(); chk("tmo_io",  outs(IO,  5'b10000));
        step(); chk("tmo_run", outs(RUN, 5'b10000));
`else
        for (int i = 0; i < 40; i++) begin
            step();
            if (i % 8 == 0 || i == 39)
                chk($sformatf("memwait%0d", i), outs(MEM, 5'b00001));
        end
        mem_ready = 1'b1;
        step(); chk("memwait_io",  outs(IO,  5'b00001));
        step(); chk("memwait_run", outs(RUN, 5'b00001));
`endif

        // Asynchronous reset in the middle of MEM, no clock edge in between
        rst_in_n = 1'b0; mem_ready = 1'b0;
        step();
        rst_in_n = 1'b1;
        repeat (16) step();
        step();
        chk("async_pre_mem", outs(MEM, 5'b00001));
        #2;
        rst_in_n = 1'b0;
        #1;
        chk("async_reset_mid_mem", outs(HOLD, 5'b00001));
        #1;
        rst_in_n = 1'b1;
        mem_ready = 1'b1;
        repeat (18) step();
        chk("async_rerelease_run", outs(RUN, 5'b00001));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer that sits behind the board clock/reset generator and owns reset release for the three reset domains of the system: memory controller, I/O, and CPU. It merges reset requests from the button, the watchdog and software, stretches each event to a fixed minimum hold time, and releases the domains in order. The CPU is released only after the memory controller reports initialisation complete. The cause of the last reset is recorded for software.

## Interface
- `HOLD_CYCLES`, default 16: minimum cycles all domains stay in reset after any reset event.
- `MEM_TIMEOUT`, default 1024: maximum cycles spent waiting for `mem_ready`; only used with the timeout option.
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `rst_in_n`, in, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `btn_rst_n`, in, 1: push-button reset, asynchronous, active-low; synchronised internally.
- `wdog_rst_req`, in, 1: watchdog reset request, synchronous level.
- `sw_rst_req`, in, 1: software reset request, synchronous single-cycle pulse.
- `mem_ready`, in, 1: memory controller initialisation done, synchronous level.
- `rst_mem`, out, 1: memory-controller domain reset, active-high.
- `rst_io`, out, 1: I/O domain reset, active-high.
- `rst_cpu`, out, 1: CPU domain reset, active-high.
- `done`, out, 1: high when every domain is released.
- `cause`, out, 5: cause of the last reset event. Bit 0 power-on, bit 1 button, bit 2 watchdog, bit 3 software, bit 4 mem timeout.

## Operation
- States: HOLD, MEM, IO, RUN. All outputs are registered and change on the edge that enters a state.
- While `rst_in_n`=0: state HOLD, counter 0, `rst_mem`=`rst_io`=`rst_cpu`=1, `done`=0, `cause`=5'b00001, synchroniser flops 1.
- HOLD: all resets 1. The counter increments each cycle; at count `HOLD_CYCLES`-1 the next state is MEM and the counter clears.
- MEM: `rst_mem`=0, others 1, counter increments. If `mem_ready`=1, the next state is IO.
- IO: `rst_mem`=`rst_io`=0, `rst_cpu`=1. Lasts exactly one cycle, then RUN.
- RUN: all resets 0, `done`=1, counter idle.
- Request = (synchronised button low) | `wdog_rst_req` | `sw_rst_req`.
  - In any state, a request forces HOLD with counter 0; all resets read 1 on the next edge.
  - A request during HOLD restarts the count, which stretches the reset.
- `cause` loads on every request cycle with the OR of the active request bits; bit 0 is cleared.
  - Simultaneous requests set multiple bits.
  - Repeated requests during HOLD overwrite `cause` with the latest set.
  - `cause` holds otherwise.
- A request takes priority over `mem_ready` and over a timeout in the same cycle.
- Counter width is `$clog2` of the larger of `HOLD_CYCLES` and `MEM_TIMEOUT`; it never wraps.

## Timing
- Power-on, `mem_ready`=1, `HOLD_CYCLES`=16. Counting in edges after `rst_in_n` deasserts:
  - `rst_mem` falls at edge 16.
  - `rst_io` falls at edge 17.
  - `rst_cpu` and `done` change at edge 18.
- Button path: 2-flop synchroniser plus 1 cycle, so 3 edges from `btn_rst_n` low to all resets 1.
- `wdog_rst_req` or `sw_rst_req`: 1 edge to all resets 1.
- `mem_ready` deasserting after MEM has no effect.

## Configuration
- `RST_SEQ_TIMEOUT_EN` defined: in MEM, when the counter reaches `MEM_TIMEOUT`-1 without `mem_ready`:
  - the next state is HOLD with counter 0;
  - `cause` = 5'b10000;
  - the sequence retries indefinitely.
- Not defined: MEM waits for `mem_ready` forever. `cause` bit 4 is tied 0 and `MEM_TIMEOUT` is ignored.

## Structure
- Package `rst_seq_pkg`: state enum (HOLD, MEM, IO, RUN) and localparams for the `cause` bit indices and the `cause` width.
- Sub-module `sync2`: a two-flop synchroniser with a reset value parameter, instantiated for `btn_rst_n` with reset value 1.

## Test plan
- Power-on, `mem_ready`=1 -> `rst_mem`/`rst_io`/`rst_cpu` fall at edges 16/17/18, `cause`=5'b00001, `done`=1 at edge 18.
- `mem_ready` held 0 for 40 cycles, then 1 -> `rst_mem`=0 throughout, `rst_io` falls 1 edge after `mem_ready` is sampled high, `rst_cpu` 1 edge later.
- In RUN, pulse `sw_rst_req` -> all resets 1 next edge, `cause`=5'b01000. Then:
  - `wdog_rst_req` held 5 cycles during HOLD -> release 16 edges after it drops, `cause`=5'b00100.
- `btn_rst_n` low and `sw_rst_req` at the same time, in RUN:
  - software effect visible after 1 edge;
  - button sync reaches the request 2 edges later;
  - final `cause`=5'b00010 (button only, as the latest event).
- `RST_SEQ_TIMEOUT_EN`, `MEM_TIMEOUT`=8, `mem_ready`=0 -> MEM lasts 8 cycles, then HOLD with `cause`=5'b10000, repeating; the cycle completes once `mem_ready`=1.
- Assert `rst_in_n`=0 mid-MEM -> all outputs at reset values immediately, with no clock needed.
